// File: rtl/delay_echo_stage.sv
// Echo/feedback stage: reads a delayed sample, writes back input + scaled feedback,
// and emits a saturated wet/dry mix, one sample at a time.
module delay_echo_stage #(
  parameter int data_width = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [data_width-1:0] in_sample,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic        [data_width-1:0] handle,
  input  logic signed [data_width-1:0] fb_gain,
  input  logic signed [data_width-1:0] wet_gain,
  input  logic signed [data_width-1:0] dry_gain,
  input  logic signed [data_width-1:0] delay_inc,
  output logic signed [data_width-1:0] out_sample,
  output logic                         out_valid,
  output logic                         error,
  output logic                         dm_read_req,
  output logic                         dm_write_req,
  output logic        [data_width-1:0] dm_read_handle,
  output logic        [data_width-1:0] dm_write_handle,
  output logic signed [data_width-1:0] dm_write_data,
  output logic signed [data_width-1:0] dm_write_inc,
  input  logic signed [data_width-1:0] dm_data_in,
  input  logic                         dm_read_valid,
  input  logic                         dm_write_ack,
  input  logic                         dm_invalid_read,
  input  logic                         dm_invalid_write
);
  localparam int PW   = 2 * data_width;
  localparam int SW   = PW + 1;
  localparam int FRAC = 14;
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, MIX, WRITE_REQ, WRITE_WAIT, OUT} state_t;

  state_t state, state_n;
  logic abort;
  logic [CW-1:0] cnt;
  logic timed_out, accept, err_r;
  logic signed [data_width-1:0] x_r, d_r, fb_r, wet_r, dry_r, inc_r, mix_r, wdata_r;
  logic [data_width-1:0] hdl_r;
  logic signed [PW-1:0] p_fb, p_dry, p_wet;
  logic signed [SW-1:0] w_sum, m_sum, dry_sum;

  // Clamp a wide signed value into data_width: fits iff all bits above the sign bit agree.
  function automatic logic signed [data_width-1:0] sat(input logic signed [SW-1:0] v);
    if ((&v[SW-1:data_width-1]) || !(|v[SW-1:data_width-1]))
      return v[data_width-1:0];
    return v[SW-1] ? {1'b1, {(data_width-1){1'b0}}} : {1'b0, {(data_width-1){1'b1}}};
  endfunction

  assign p_fb    = PW'(d_r) * PW'(fb_r);
  assign p_dry   = PW'(x_r) * PW'(dry_r);
  assign p_wet   = PW'(d_r) * PW'(wet_r);
  assign w_sum   = SW'(x_r) + SW'(p_fb >>> FRAC);
  assign m_sum   = (SW'(p_dry) + SW'(p_wet)) >>> FRAC;
  assign dry_sum = SW'(p_dry >>> FRAC);

  assign timed_out = (cnt + CW'(1)) == CW'(TIMEOUT);
  assign in_ready  = reset && enable && (state == IDLE);
  assign accept    = in_ready && in_valid;

  assign dm_read_req     = enable && (state == READ_REQ);
  assign dm_write_req    = enable && (state == WRITE_REQ);
  assign out_valid       = enable && (state == OUT);
  assign error           = out_valid && err_r;
  assign dm_read_handle  = hdl_r;
  assign dm_write_handle = hdl_r;
  assign dm_write_data   = wdata_r;
  assign dm_write_inc    = inc_r;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;

  // Valid responses take priority over rejects and over the timeout.
  always_comb begin
    state_n = state;
    abort   = 1'b0;
    if (enable) begin
      case (state)
        IDLE:       if (in_valid) state_n = READ_REQ;
        READ_REQ:   state_n = READ_WAIT;
        READ_WAIT:  if (dm_read_valid) state_n = MIX;
                    else if (dm_invalid_read || timed_out) begin
                      state_n = OUT;
                      abort   = 1'b1;
                    end
        MIX:        state_n = WRITE_REQ;
        WRITE_REQ:  state_n = WRITE_WAIT;
        WRITE_WAIT: if (dm_write_ack) state_n = OUT;
                    else if (dm_invalid_write || timed_out) begin
                      state_n = OUT;
                      abort   = 1'b1;
                    end
        OUT:        state_n = IDLE;
        default:    state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r <= '0; d_r <= '0; fb_r <= '0; wet_r <= '0; dry_r <= '0; inc_r <= '0;
      hdl_r <= '0; mix_r <= '0; wdata_r <= '0; out_sample <= '0; err_r <= 1'b0; cnt <= '0;
    end else if (enable) begin
      if (accept) begin
        x_r <= in_sample; hdl_r <= handle; fb_r <= fb_gain;
        wet_r <= wet_gain; dry_r <= dry_gain; inc_r <= delay_inc; err_r <= 1'b0;
      end
      if (state == READ_REQ || state == WRITE_REQ) cnt <= '0;
      else if (state == READ_WAIT || state == WRITE_WAIT) cnt <= cnt + CW'(1);
      if (state == READ_WAIT && dm_read_valid) d_r <= dm_data_in;
      if (state == MIX) begin
        wdata_r <= sat(w_sum);
        mix_r   <= sat(m_sum);
      end
      if (state == WRITE_WAIT && dm_write_ack) out_sample <= mix_r;
      if (abort) begin
        out_sample <= sat(dry_sum);
        err_r      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_delay_echo_stage.sv
// Scoreboard bench for delay_echo_stage: random and directed samples against an
// arithmetic reference model, with a behavioural delay-master responder.
module tb_delay_echo_stage;
  localparam int DW = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset, enable, in_valid, in_ready;
  logic signed [DW-1:0] in_sample, fb_gain, wet_gain, dry_gain, delay_inc;
  logic [DW-1:0] handle;
  logic signed [DW-1:0] out_sample, dm_write_data, dm_write_inc, dm_data_in;
  logic out_valid, error, dm_read_req, dm_write_req;
  logic [DW-1:0] dm_read_handle, dm_write_handle;
  logic dm_read_valid, dm_write_ack, dm_invalid_read, dm_invalid_write;

  delay_echo_stage #(.data_width(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .handle(handle), .fb_gain(fb_gain), .wet_gain(wet_gain), .dry_gain(dry_gain),
    .delay_inc(delay_inc), .out_sample(out_sample), .out_valid(out_valid), .error(error),
    .dm_read_req(dm_read_req), .dm_write_req(dm_write_req),
    .dm_read_handle(dm_read_handle), .dm_write_handle(dm_write_handle),
    .dm_write_data(dm_write_data), .dm_write_inc(dm_write_inc), .dm_data_in(dm_data_in),
    .dm_read_valid(dm_read_valid), .dm_write_ack(dm_write_ack),
    .dm_invalid_read(dm_invalid_read), .dm_invalid_write(dm_invalid_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { longint exp_out; longint exp_err; int lat; int t0; } exp_t;
  typedef struct { longint data; longint hdl; longint inc; } wexp_t;
  exp_t   sb[$];
  wexp_t  wq[$];
  longint rq[$];

  // master response config, captured by the responder when it sees a request
  int m_d, m_rl, m_rm, m_wl, m_wm;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: required event did not occur as expected (cycle %0d)", name, cyc);
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int rs16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  // Modes: 0 = valid, 1 = invalid, 2 = no response, 3 = valid and invalid together.
  initial begin
    int rp, rc, wp, wc, rm, wm;
    logic signed [15:0] dv;
    rp = 0; rc = 0; wp = 0; wc = 0; rm = 0; wm = 0; dv = '0;
    dm_read_valid = 0; dm_write_ack = 0; dm_invalid_read = 0; dm_invalid_write = 0;
    dm_data_in = '0;
    forever begin
      @(negedge clk);
      dm_read_valid = 0; dm_write_ack = 0; dm_invalid_read = 0; dm_invalid_write = 0;
      dm_data_in = 16'($urandom);
      if (rp != 0) begin
        rc--;
        if (rc == 0) begin
          rp = 0;
          dm_data_in = dv;
          if (rm == 0 || rm == 3) dm_read_valid = 1;
          if (rm == 1 || rm == 3) dm_invalid_read = 1;
        end
      end
      if (wp != 0) begin
        wc--;
        if (wc == 0) begin
          wp = 0;
          if (wm == 0 || wm == 3) dm_write_ack = 1;
          if (wm == 1 || wm == 3) dm_invalid_write = 1;
        end
      end
      if (dm_read_req)  begin rp = 1; rc = m_rl; rm = m_rm; dv = 16'(m_d); end
      if (dm_write_req) begin wp = 1; wc = m_wl; wm = m_wm; end
      if (!reset) begin rp = 0; wp = 0; end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result or a request.
  initial begin
    exp_t e;
    wexp_t w;
    longint h;
    forever begin
      @(negedge clk);
      if (error && !out_valid) fail("error_without_out_valid");
      if (out_valid) begin
        if (sb.size() == 0) fail("unexpected_out_valid");
        else begin
          e = sb.pop_front();
          chk("out_sample", longint'($signed(out_sample)), e.exp_out);
          chk("error", longint'(error), e.exp_err);
          chk("latency", longint'(cyc - e.t0), longint'(e.lat));
        end
      end
      if (dm_write_req) begin
        if (wq.size() == 0) fail("unexpected_dm_write_req");
        else begin
          w = wq.pop_front();
          chk("dm_write_data", longint'($signed(dm_write_data)), w.data);
          chk("dm_write_handle", longint'(dm_write_handle), w.hdl);
          chk("dm_write_inc", longint'($signed(dm_write_inc)), w.inc);
        end
      end
      if (dm_read_req) begin
        if (rq.size() == 0) fail("unexpected_dm_read_req");
        else begin
          h = rq.pop_front();
          chk("dm_read_handle", longint'(dm_read_handle), h);
        end
      end
    end
  end

  task automatic issue(input int x, input int h, input int fb, input int wg, input int dg,
                       input int inc, input int d, input int rl, input int rm,
                       input int wl, input int wm, input int extra);
    exp_t e;
    wexp_t w;
    longint dry, mix, wd;
    bit rok, wok;
    int guard;
    guard = 0;
    @(posedge clk); #2;
    while (!in_ready && guard < 300) begin @(posedge clk); #2; guard++; end
    if (!in_ready) begin fail("in_ready_wait"); return; end
    in_sample = 16'(x); handle = 16'(h); fb_gain = 16'(fb); wet_gain = 16'(wg);
    dry_gain = 16'(dg); delay_inc = 16'(inc); in_valid = 1;
    m_d = d; m_rl = rl; m_rm = rm; m_wl = wl; m_wm = wm;
    dry = sat((longint'(x) * dg) >>> 14);
    mix = sat((longint'(x) * dg + longint'(d) * wg) >>> 14);
    wd  = sat(longint'(x) + ((longint'(d) * fb) >>> 14));
    rok = (rm == 0 || rm == 3);
    wok = (wm == 0 || wm == 3);
    e.t0 = cyc;
    if (!rok) begin
      e.exp_out = dry; e.exp_err = 1; e.lat = (rm == 1) ? 2 + rl : 2 + TO;
    end else if (wok) begin
      e.exp_out = mix; e.exp_err = 0; e.lat = 4 + rl + wl;
    end else begin
      e.exp_out = dry; e.exp_err = 1; e.lat = (wm == 1) ? 4 + rl + wl : 4 + rl + TO;
    end
    e.lat += extra;
    sb.push_back(e);
    rq.push_back(longint'(h));
    if (rok) begin
      w.data = wd; w.hdl = longint'(h); w.inc = longint'(inc);
      wq.push_back(w);
    end
    @(posedge clk); #2;
    in_valid = 0;
    in_sample = 16'($urandom); handle = 16'($urandom); fb_gain = 16'($urandom);
    wet_gain = 16'($urandom); dry_gain = 16'($urandom); delay_inc = 16'($urandom);
  endtask

  task automatic wait_write_req(output bit seen);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (dm_write_req) seen = 1;
    end
  endtask

  initial begin
    bit seen;
    int rm, wm, r;
    reset = 0; enable = 1; in_valid = 0;
    in_sample = '0; handle = '0; fb_gain = '0; wet_gain = '0; dry_gain = '0; delay_inc = '0;
    m_d = 0; m_rl = 2; m_rm = 0; m_wl = 1; m_wm = 0;

    @(negedge clk);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_sample", longint'(out_sample), 0);
    chk("reset_dm_read_req", longint'(dm_read_req), 0);
    chk("reset_dm_write_data", longint'(dm_write_data), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1;
    #1 chk("in_ready_after_reset", longint'(in_ready), 1);

    issue(1000, 16'h0011, 0, 16384, 0, 3, 500, 2, 0, 1, 0, 0);
    issue(1000, 16'h0022, 8192, 8192, 16384, -2, 400, 2, 0, 1, 0, 0);
    issue(30000, 16'h0033, 16384, 16384, 16384, 5, 20000, 2, 0, 2, 0, 0);
    issue(-30000, 16'h0044, 16384, 16384, 16384, -5, -20000, 3, 0, 1, 0, 0);

    // invalid read in T2 aborts before any write
    issue(1000, 16'h0055, 4096, 16384, 8192, 1, 700, 1, 1, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) fail("read_abort_out_valid");
    @(negedge clk);
    chk("in_ready_after_abort", longint'(in_ready), 1);

    issue(1234, 16'h0066, 1000, 9000, 12000, 9, 321, 2, 3, 2, 3, 0);
    issue(-777, 16'h0077, 2000, 3000, 16384, 0, 55, 2, 0, 1, 2, 0);
    issue(900, 16'h0088, 0, 0, 16384, 0, 11, 2, 2, 1, 0, 0);
    issue(-500, 16'h0099, 0, 0, -32768, 0, 11, 2, 0, 2, 1, 0);

    // write timeout stretched by 10 disabled cycles
    issue(1000, 16'h00aa, 0, 16384, 16384, 4, 300, 2, 0, 1, 2, 10);
    wait_write_req(seen);
    if (!seen) fail("enable_test_write_req");
    repeat (20) @(posedge clk);
    #2 enable = 0;
    repeat (10) @(posedge clk);
    #2 enable = 1;

    // reset while waiting for a write ack drops the sample
    issue(2000, 16'h1234, 0, 16384, 16384, 77, 100, 2, 0, 1, 2, 0);
    wait_write_req(seen);
    if (!seen) fail("reset_test_write_req");
    repeat (5) @(negedge clk);
    #1 reset = 0;
    #1;
    chk("midreset_out_sample", longint'(out_sample), 0);
    chk("midreset_out_valid", longint'(out_valid), 0);
    chk("midreset_error", longint'(error), 0);
    chk("midreset_in_ready", longint'(in_ready), 0);
    chk("midreset_dm_write_req", longint'(dm_write_req), 0);
    chk("midreset_dm_read_handle", longint'(dm_read_handle), 0);
    chk("midreset_dm_write_handle", longint'(dm_write_handle), 0);
    chk("midreset_dm_write_data", longint'(dm_write_data), 0);
    chk("midreset_dm_write_inc", longint'(dm_write_inc), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1;
    #1 chk("in_ready_after_midreset", longint'(in_ready), 1);
    issue(1500, 16'h4321, 4096, 8192, 8192, 12, -600, 2, 0, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      rm = (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 3 : 2;
      r  = $urandom_range(0, 9);
      wm = (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 3 : 2;
      issue(rs16(), $urandom_range(0, 65535), rs16(), rs16(), rs16(), rs16(), rs16(),
            $urandom_range(1, 4), rm, $urandom_range(1, 3), wm, 0);
    end

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", longint'(sb.size()), 0);
    chk("write_queue_drained", longint'(wq.size()), 0);
    chk("read_queue_drained", longint'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
